// File: rtl/vga_quad_pkg.sv
// Shared constants, quadrant encodings and the colour-bar helper for the VGA quadrant renderer.
// Default timing is 640x480 @ 800x525 totals; the modules take the individual intervals as parameters.
package vga_quad_pkg;

  localparam int CNT_W = 10;
  localparam int BAR_W = 12;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC;
  localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC;

  typedef enum logic [1:0] {
    QUAD_LU = 2'd0,
    QUAD_RU = 2'd1,
    QUAD_LD = 2'd2,
    QUAD_RD = 2'd3
  } quad_e;

  function automatic quad_e quad_select(input logic right, input logic bottom);
    return quad_e'({bottom, right});
  endfunction

  // Each bar index bit drives one full RGB444 channel.
  function automatic logic [BAR_W-1:0] bar_color(input logic [2:0] idx);
    return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster counters with sync/active decode and the end-of-frame commit strobe.
// rst_n is asserted high and sampled synchronously; counting starts one cycle after release.
module vga_timing_counter
  import vga_quad_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             run_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hsync_n_o,
  output logic             vsync_n_o,
  output logic             active_o,
  output logic             frame_start_o,
  output logic             commit_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_FIN = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_FIN = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);

  logic             run_q;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_last, v_last;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    // NOTE: defaults first so every path assigns the next-state values; a missing branch would infer a latch.
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_q) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    if (rst_n) begin
      run_q   <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      run_q   <= 1'b1;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign run_o         = run_q;
  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign hsync_n_o     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_FIN));
  assign vsync_n_o     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_FIN));
  assign active_o      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign commit_o      = run_q && h_last && v_last;

endmodule

// File: rtl/vga_quad_renderer.sv
// Double-buffered four-quadrant colour renderer: writes land in a shadow bank that is
// committed to the live bank, together with the split/debug controls, on the last pixel of each frame.
module vga_quad_renderer
  import vga_quad_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 2,
  parameter int C_DATA_WIDTH = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [C_ADDR_WIDTH-1:0] c_addr,
  input  logic [C_DATA_WIDTH-1:0] c_data,
  input  logic                    c_valid,
  output logic                    c_ready,
  input  logic                    Vertical_Split,
  input  logic                    Horizontal_Split,
  input  logic                    VGA_debug,
  output logic                    HSync,
  output logic                    VSync,
  output logic [DATA_WIDTH-1:0]   Data_VGA,
  output logic                    Active,
  output logic                    Frame_Start
);

  localparam int               N_QUAD  = 1 << C_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] H_HALF  = CNT_W'(H_ACTIVE / 2);
  localparam logic [CNT_W-1:0] V_HALF  = CNT_W'(V_ACTIVE / 2);
  localparam logic [CNT_W-1:0] BAR_PIX = CNT_W'(H_ACTIVE / 8);

  logic             run, commit;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             hsync_n, vsync_n, active, frame_start;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_o        (run),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .hsync_n_o    (hsync_n),
    .vsync_n_o    (vsync_n),
    .active_o     (active),
    .frame_start_o(frame_start),
    .commit_o     (commit)
  );

  logic [C_DATA_WIDTH-1:0] shadow_q [N_QUAD];
  logic [C_DATA_WIDTH-1:0] live_q   [N_QUAD];
  logic                    vsplit_q, hsplit_q, debug_q;
  logic                    hsync_q, vsync_q, active_q, frame_start_q;
  logic [DATA_WIDTH-1:0]   data_q, pixel_d;
  logic                    wr_fire;
  quad_e                   quad;
  logic [2:0]              bar_idx;

  // The commit cycle refuses writes so the shadow copy into the live bank is never torn.
  assign c_ready = !rst_n && run && !commit;
  assign wr_fire = c_valid && c_ready;

  assign quad    = quad_select(vsplit_q && (h_cnt >= H_HALF), hsplit_q && (v_cnt >= V_HALF));
  assign bar_idx = 3'(h_cnt / BAR_PIX);

  always_comb begin
    pixel_d = '0;
    if (active) begin
      if (debug_q) pixel_d = DATA_WIDTH'(bar_color(bar_idx));
      else         pixel_d = DATA_WIDTH'(live_q[quad]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      // NOTE: the banks are four flop words, not a RAM, so reset clears them like any other state.
      for (int i = 0; i < N_QUAD; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      vsplit_q      <= 1'b0;
      hsplit_q      <= 1'b0;
      debug_q       <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      data_q        <= '0;
    end else begin
      if (wr_fire) shadow_q[c_addr] <= c_data;
      if (commit) begin
        for (int i = 0; i < N_QUAD; i++) live_q[i] <= shadow_q[i];
        vsplit_q <= Vertical_Split;
        hsplit_q <= Horizontal_Split;
        debug_q  <= VGA_debug;
      end
      // Output stage holds its reset values until the counters begin running.
      if (run) begin
        hsync_q       <= hsync_n;
        vsync_q       <= vsync_n;
        active_q      <= active;
        frame_start_q <= frame_start;
        data_q        <= pixel_d;
      end
    end
  end

  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign Active      = active_q;
  assign Frame_Start = frame_start_q;
  assign Data_VGA    = data_q;

endmodule

// File: tb/tb_vga_quad_renderer.sv
// Scoreboard bench for vga_quad_renderer on a shrunken raster, compared against a frame-level model.
module tb_vga_quad_renderer;

  localparam int HA = 32, HFP = 2, HSW = 4, HBP = 2;
  localparam int VA = 24, VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  c_addr;
  logic [11:0] c_data;
  logic        c_valid, c_ready;
  logic        vsplit_in, hsplit_in, dbg_in;
  logic        HSync, VSync, Active, Frame_Start;
  logic [11:0] Data_VGA;

  vga_quad_renderer #(
    .C_ADDR_WIDTH(2), .C_DATA_WIDTH(12), .DATA_WIDTH(12),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .c_addr          (c_addr),
    .c_data          (c_data),
    .c_valid         (c_valid),
    .c_ready         (c_ready),
    .Vertical_Split  (vsplit_in),
    .Horizontal_Split(hsplit_in),
    .VGA_debug       (dbg_in),
    .HSync           (HSync),
    .VSync           (VSync),
    .Data_VGA        (Data_VGA),
    .Active          (Active),
    .Frame_Start     (Frame_Start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hs, vs, act, fs;
    logic [11:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;

  // Frame-level reference model state.
  bit          m_run;
  int          m_t;
  logic [11:0] m_shadow [4];
  logic [11:0] m_live   [4];
  bit          m_vsplit, m_hsplit, m_dbg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t expect_at(int x, int y);
    exp_t e;
    int   i, idx;
    e.act  = (x < HA) && (y < VA);
    e.hs   = !(x >= HA + HFP && x < HA + HFP + HSW);
    e.vs   = !(y >= VA + VFP && y < VA + VFP + VSW);
    e.fs   = (x == 0) && (y == 0);
    e.data = 12'h000;
    if (e.act) begin
      if (m_dbg) begin
        i = x / (HA / 8);
        if (i >= 4)     e.data = e.data | 12'hF00;
        if (i % 4 >= 2) e.data = e.data | 12'h0F0;
        if (i % 2 == 1) e.data = e.data | 12'h00F;
      end else begin
        idx = ((m_hsplit && y >= VA / 2) ? 2 : 0) + ((m_vsplit && x >= HA / 2) ? 1 : 0);
        e.data = m_live[idx];
      end
    end
    return e;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 12'h000;
      m_live[i]   = 12'h000;
    end
    m_vsplit = 0; m_hsplit = 0; m_dbg = 0;
    m_run = 0; m_t = 0;
  endfunction

  // Called at a falling edge with inputs already set; models the coming rising edge.
  task automatic step(output bit acc);
    int   x, y;
    bit   commit, rdy;
    exp_t e;
    #1;
    x      = m_t % HT;
    y      = (m_t / HT) % VT;
    commit = m_run && x == HT - 1 && y == VT - 1;
    rdy    = !rst_n && m_run && !commit;
    check("c_ready", {31'd0, c_ready}, {31'd0, rdy});
    if (rst_n || !m_run) begin
      e.hs = 1; e.vs = 1; e.act = 0; e.fs = 0; e.data = 12'h000;
    end else begin
      e = expect_at(x, y);
    end
    exp_q.push_back(e);
    acc = c_valid && rdy;
    if (rst_n) begin
      model_clear();
    end else begin
      if (acc) m_shadow[c_addr] = c_data;
      if (commit) begin
        m_live   = m_shadow;
        m_vsplit = vsplit_in;
        m_hsplit = hsplit_in;
        m_dbg    = dbg_in;
      end
      if (m_run) m_t++;
      m_run = 1;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    bit a;
    step(a);
  endtask

  task automatic run_until(input int x, input int y);
    int n = 0;
    while (!(m_run && m_t % HT == x && (m_t / HT) % VT == y) && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  task automatic next_frame();
    run_until(HT - 1, VT - 1);
    tick();
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [11:0] data);
    bit a;
    c_valid = 1; c_addr = addr; c_data = data;
    for (int n = 0; n < 4; n++) begin
      step(a);
      if (a) break;
    end
    c_valid = 0;
  endtask

  // Monitor: pops one expectation per rising edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("HSync",       {31'd0, HSync},       {31'd0, e.hs});
        check("VSync",       {31'd0, VSync},       {31'd0, e.vs});
        check("Active",      {31'd0, Active},      {31'd0, e.act});
        check("Frame_Start", {31'd0, Frame_Start}, {31'd0, e.fs});
        check("Data_VGA",    {20'd0, Data_VGA},    {20'd0, e.data});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1; c_valid = 0; c_addr = 0; c_data = 0;
    vsplit_in = 0; hsplit_in = 0; dbg_in = 0;
    model_clear();
    @(negedge clk);
    repeat (3) tick();
    rst_n = 0;

    // Frame 0: write quadrant 0; it must only show from frame 1.
    run_until(5, 3);
    do_write(2'd0, 12'hA5A);
    next_frame();

    // Frame 1: quadrant colours (last write wins), splits on, write right before commit.
    run_until(2, 1);
    do_write(2'd0, 12'h777);
    do_write(2'd0, 12'hF00);
    do_write(2'd1, 12'h0F0);
    do_write(2'd2, 12'h00F);
    do_write(2'd3, 12'h0AB);
    run_until(0, 10);
    vsplit_in = 1; hsplit_in = 1;
    run_until(HT - 2, VT - 1);
    do_write(2'd3, 12'hFFF);
    tick();

    // Frame 2: write held through the commit cycle, accepted one cycle later.
    run_until(HT - 1, VT - 1);
    do_write(2'd1, 12'h5C3);

    // Frame 3: mid-frame split change, visible from frame 4.
    run_until(0, 5);
    hsplit_in = 0;
    next_frame();

    // Frame 4: enable the bar pattern for frame 5.
    run_until(0, 7);
    dbg_in = 1;
    next_frame();

    run_until(3, 3);
    dbg_in = 0; vsplit_in = 0;
    next_frame();

    // Random traffic, including a mid-frame reset.
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        c_valid = ($urandom_range(0, 29) == 0);
        c_addr  = 2'($urandom_range(0, 3));
        c_data  = 12'($urandom);
        if ($urandom_range(0, 199) == 0) vsplit_in = !vsplit_in;
        if ($urandom_range(0, 199) == 0) hsplit_in = !hsplit_in;
        if ($urandom_range(0, 599) == 0) dbg_in = !dbg_in;
        if (f == 2 && c == 500) rst_n = 1;
        if (f == 2 && c == 502) rst_n = 0;
        tick();
      end
    end
    c_valid = 0;
    repeat (3) tick();

    @(posedge clk);
    #2;
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
